// File: rtl/real_avg_pkg.sv
// Shared definitions for the real-valued moving-average stage:
// FSM state encoding and the window-depth legality check.
package real_avg_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Window length must be a power of two in 2..64 so the pointer wraps for free.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && (depth <= 64) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/real_window_buf.sv
// DEPTH-entry circular buffer of reals; exposes the oldest entry (at wr_ptr)
// combinationally so it can be subtracted before the same-edge overwrite.
module real_window_buf #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wr_en,
  input  real  din,
  output real  oldest
);
  localparam int AW = $clog2(DEPTH);

  real            mem [DEPTH];
  logic [AW-1:0]  wr_ptr;

  assign oldest = mem[wr_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 0.0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 0.0;
    end else if (wr_en) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

endmodule

// File: rtl/real_moving_avg.sv
// Registered mean of the last min(count, DEPTH) real samples, 1-cycle latency, no backpressure.
// Optional output clamp to [CLAMP_MIN, CLAMP_MAX] with macro REAL_MOVING_AVG_CLAMP_EN.
module real_moving_avg
  import real_avg_pkg::*;
#(
  parameter int  DEPTH     = 4,
  parameter real RESET_VAL = 0.0,
  parameter real CLAMP_MIN = -100.0,
  parameter real CLAMP_MAX = 100.0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  real                    data_i,
  output real                    data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("real_moving_avg: DEPTH must be a power of two in 2..64");
  end
  if (CLAMP_MIN > CLAMP_MAX) begin : g_bad_clamp
    $error("real_moving_avg: CLAMP_MIN exceeds CLAMP_MAX");
  end

  state_t         state, state_next;
  real            sum, sum_next, mean, mean_out, oldest;
  logic [CW-1:0]  count, count_next;
  logic           accept;

  assign accept = valid_i && !clear_i;

  real_window_buf #(.DEPTH(DEPTH)) u_buf (
    .clk    (clk_i),
    .rst    (reset_i),
    .clear  (clear_i),
    .wr_en  (accept),
    .din    (data_i),
    .oldest (oldest)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_FILL;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    sum_next   = sum + data_i;
    count_next = count + CW'(1);
    if (state == ST_RUN) begin
      sum_next   = sum + data_i - oldest;
      count_next = count;
    end
    mean     = sum_next / real'(count_next);
    mean_out = mean;
`ifdef REAL_MOVING_AVG_CLAMP_EN
    if (mean > CLAMP_MAX)      mean_out = CLAMP_MAX;
    else if (mean < CLAMP_MIN) mean_out = CLAMP_MIN;
`endif
    if (clear_i)
      state_next = ST_FILL;
    else if (accept && state == ST_FILL && count_next == DEPTH_C)
      state_next = ST_RUN;
  end

  // Sum is kept unclamped; only the registered output sees the clamp.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sum     <= 0.0;
      count   <= '0;
      data_o  <= RESET_VAL;
      valid_o <= 1'b0;
    end else if (clear_i) begin
      sum     <= 0.0;
      count   <= '0;
      data_o  <= RESET_VAL;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sum    <= sum_next;
        count  <= count_next;
        data_o <= mean_out;
      end
    end
  end

  assign full_o  = (state == ST_RUN);
  assign count_o = count;

endmodule

// File: tb/tb_real_moving_avg.sv
// Directed bench for real_moving_avg (DEPTH=4, RESET_VAL=0.0).
module tb_real_moving_avg;
  logic       clk_i = 1'b0;
  logic       reset_i, clear_i, valid_i;
  real        data_i;
  real        data_o;
  logic       valid_o, full_o;
  logic [2:0] count_o;
  int         errors = 0;
  int         checks = 0;

  real_moving_avg #(
    .DEPTH(4), .RESET_VAL(0.0), .CLAMP_MIN(-100.0), .CLAMP_MAX(100.0)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .full_o  (full_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_r(input string tag, input real obs, input real exp);
    checks++;
    assert ((obs - exp) < 1.0e-9 && (exp - obs) < 1.0e-9)
    else begin
      errors++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input real d, input logic v,
                         input logic f, input logic [2:0] c);
    chk_r({tag, ".data"}, data_o, d);
    chk_l({tag, ".valid"}, {2'b0, valid_o}, {2'b0, v});
    chk_l({tag, ".full"}, {2'b0, full_o}, {2'b0, f});
    chk_l({tag, ".count"}, count_o, c);
  endtask

  // Drive inputs, take one rising edge, and leave the bench #1 past it.
  task automatic step(input logic v, input real d, input logic c);
    valid_i = v;
    data_i  = d;
    clear_i = c;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    data_i  = 0.0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset", 0.0, 1'b0, 1'b0, 3'd0);
    reset_i = 1'b0;

    // Fill then run: means 1.0 1.5 2.0 2.5 3.5
    step(1'b1, 1.0, 1'b0); chk_all("fill1", 1.0, 1'b1, 1'b0, 3'd1);
    step(1'b1, 2.0, 1'b0); chk_all("fill2", 1.5, 1'b1, 1'b0, 3'd2);
    step(1'b1, 3.0, 1'b0); chk_all("fill3", 2.0, 1'b1, 1'b0, 3'd3);
    step(1'b1, 4.0, 1'b0); chk_all("fill4", 2.5, 1'b1, 1'b1, 3'd4);
    step(1'b1, 5.0, 1'b0); chk_all("run5",  3.5, 1'b1, 1'b1, 3'd4);
    step(1'b0, 0.0, 1'b0); chk_all("idle",  3.5, 1'b0, 1'b1, 3'd4);

    // Gaps: data holds through idle cycles
    step(1'b0, 0.0, 1'b1); chk_all("clr_a", 0.0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 2.0, 1'b0); chk_all("gap1",  2.0, 1'b1, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 9.0, 1'b0); chk_all("gap_idle", 2.0, 1'b0, 1'b0, 3'd1);
    end
    step(1'b1, 4.0, 1'b0); chk_all("gap2",  3.0, 1'b1, 1'b0, 3'd2);

    // Clear wins over a same-cycle valid
    step(1'b0, 0.0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8.0, 1'b0);
    chk_all("eight4", 8.0, 1'b1, 1'b1, 3'd4);
    step(1'b1, 1.0, 1'b1); chk_all("clr_pri", 0.0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 6.0, 1'b0); chk_all("after_clr", 6.0, 1'b1, 1'b0, 3'd1);

    // Asynchronous reset between edges after 6 samples (1..6 -> mean 4.5)
    step(1'b0, 0.0, 1'b1);
    for (int k = 1; k <= 6; k++) step(1'b1, real'(k), 1'b0);
    chk_all("pre_rst", 4.5, 1'b1, 1'b1, 3'd4);
    #2 reset_i = 1'b1;
    #1;
    chk_all("async_rst", 0.0, 1'b0, 1'b0, 3'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    step(1'b1, 7.0, 1'b0); chk_all("post_rst", 7.0, 1'b1, 1'b0, 3'd1);

    // Wrap-around: samples 1..12, last four are 9..12
    step(1'b0, 0.0, 1'b1);
    for (int k = 1; k <= 12; k++) step(1'b1, real'(k), 1'b0);
    chk_all("wrap", 10.5, 1'b1, 1'b1, 3'd4);

    // Clamp behaviour depends on build configuration
    step(1'b0, 0.0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 500.0, 1'b0);
`ifdef REAL_MOVING_AVG_CLAMP_EN
    chk_all("clamp", 100.0, 1'b1, 1'b1, 3'd4);
`else
    chk_all("clamp", 500.0, 1'b1, 1'b1, 3'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
